tpu_host_seq: RTL and testbench

- Host-side initiator for the TPU pin protocol.
- Captures two 2x2 int8 operand matrices on `start`, then drives the TPU's load interface, waits for `done`, and reads back the four C bytes through the output-select interface.
- Presents C as one registered word with a single-cycle valid pulse.
- Sits between an on-chip test controller or SoC register block and the TPU's ui_in/uio_in/uo_out/uio_out pins.

---
 rtl/tpu_pkg.sv | 22 ++
 rtl/tpu_uio_pack.sv | 24 ++
 rtl/tpu_host_seq.sv | 216 +++++++++++++++++++++
 tb/tb_tpu_host_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and pin-map constants for the TPU host sequencer.
// Used by tpu_host_seq and tpu_uio_pack.
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_DONE = 3'd2,
    READ      = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int LOAD_EN_BIT = 0;
  localparam int SEL_AB_BIT  = 1;
  localparam int IDX_LSB     = 2;
  localparam int OUT_EN_BIT  = 4;
  localparam int OUT_SEL_LSB = 5;

  localparam int N_ELEM   = 4;
  localparam int LOAD_CYC = 2 * N_ELEM;

endpackage

// File: rtl/tpu_uio_pack.sv
// Packs the TPU control fields into the 8-bit uio_in word; bit 7 is always 0.
// Purely combinational so a TPU-side bench can reuse it.
module tpu_uio_pack
  import tpu_pkg::*;
(
  input  logic       load_en,
  input  logic       sel_ab,
  input  logic [1:0] index,
  input  logic       output_en,
  input  logic [1:0] output_sel,
  output logic [7:0] uio
);

  // field placement into the uio word
  always_comb begin
    uio                     = 8'd0;
    uio[LOAD_EN_BIT]        = load_en;
    uio[SEL_AB_BIT]         = sel_ab;
    uio[IDX_LSB +: 2]       = index;
    uio[OUT_EN_BIT]         = output_en;
    uio[OUT_SEL_LSB +: 2]   = output_sel;
  end

endmodule

// File: rtl/tpu_host_seq.sv
// Host-side sequencer: loads two 2x2 operands into the TPU, waits for done, reads back C.
// Optional WAIT_DONE timeout is enabled by defining TPU_SEQ_TIMEOUT_EN.
module tpu_host_seq
  import tpu_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int READ_LAT    = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [N_ELEM*DATA_W-1:0]   a_flat,
  input  logic [N_ELEM*DATA_W-1:0]   b_flat,
  output logic                       busy,
  output logic [N_ELEM*DATA_W-1:0]   c_flat,
  output logic                       result_valid,
  output logic [DATA_W-1:0]          tpu_ui_in,
  output logic [7:0]                 tpu_uio_in,
  input  logic [DATA_W-1:0]          tpu_uo_out,
  input  logic                       tpu_done
`ifdef TPU_SEQ_TIMEOUT_EN
  ,
  output logic                       timeout_err
`endif
);

  localparam int         VEC_W    = N_ELEM * DATA_W;
  localparam logic [1:0] LAST_SUB = 2'(READ_LAT);

  state_t            state, state_n;
  logic [2:0]        load_k, load_k_n;
  logic [1:0]        elem, elem_n;
  logic [1:0]        sub, sub_n;
  logic [VEC_W-1:0]  a_cap, b_cap, c_smp;
  logic [VEC_W-1:0]  a_src, b_src;
  logic              capture, sample, finish_read;
  logic              ld_n, oe_n, sel_ab_n;
  logic [1:0]        idx_n, osel_n;
  logic [DATA_W-1:0] ui_n;
  logic [7:0]        uio_n;
`ifdef TPU_SEQ_TIMEOUT_EN
  logic [15:0]       wait_cnt, wait_cnt_n;
  logic              timeout_hit;
`endif

  // next-state and datapath strobes
  always_comb begin
    state_n     = state;
    load_k_n    = load_k;
    elem_n      = elem;
    sub_n       = sub;
    capture     = 1'b0;
    sample      = 1'b0;
    finish_read = 1'b0;
`ifdef TPU_SEQ_TIMEOUT_EN
    wait_cnt_n  = wait_cnt;
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = LOAD;
          load_k_n = 3'd0;
          capture  = 1'b1;
        end else begin
          state_n  = IDLE;
        end
      end
      LOAD: begin
        if (load_k == 3'(LOAD_CYC - 1)) begin
          state_n    = WAIT_DONE;
`ifdef TPU_SEQ_TIMEOUT_EN
          wait_cnt_n = 16'd0;
`endif
        end else begin
          load_k_n = load_k + 3'd1;
        end
      end
      WAIT_DONE: begin
        if (tpu_done) begin
          state_n = READ;
          elem_n  = 2'd0;
          sub_n   = 2'd0;
        end else begin
`ifdef TPU_SEQ_TIMEOUT_EN
          // give up after TIMEOUT_CYC cycles; c_flat is left untouched
          if (wait_cnt == 16'(TIMEOUT_CYC - 1)) begin
            state_n     = DONE;
            timeout_hit = 1'b1;
          end else begin
            wait_cnt_n  = wait_cnt + 16'd1;
          end
`else
          state_n = WAIT_DONE;
`endif
        end
      end
      READ: begin
        if (sub == LAST_SUB) begin
          sample = 1'b1;
          sub_n  = 2'd0;
          if (elem == 2'(N_ELEM - 1)) begin
            state_n     = DONE;
            finish_read = 1'b1;
          end else begin
            elem_n = elem + 2'd1;
          end
        end else begin
          sub_n = sub + 2'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // pin values for the next cycle, derived from the next state so pins and state stay aligned
  always_comb begin
    a_src    = capture ? a_flat : a_cap;
    b_src    = capture ? b_flat : b_cap;
    ld_n     = (state_n == LOAD);
    oe_n     = (state_n == READ);
    sel_ab_n = 1'b0;
    idx_n    = 2'd0;
    osel_n   = 2'd0;
    ui_n     = {DATA_W{1'b0}};
    if (ld_n) begin
      sel_ab_n = load_k_n[2];
      idx_n    = load_k_n[1:0];
      if (load_k_n[2]) begin
        ui_n = b_src[load_k_n[1:0]*DATA_W +: DATA_W];
      end else begin
        ui_n = a_src[load_k_n[1:0]*DATA_W +: DATA_W];
      end
    end else begin
      ui_n = {DATA_W{1'b0}};
    end
    if (oe_n) begin
      osel_n = elem_n;
    end else begin
      osel_n = 2'd0;
    end
  end

  tpu_uio_pack u_pack (
    .load_en    (ld_n),
    .sel_ab     (sel_ab_n),
    .index      (idx_n),
    .output_en  (oe_n),
    .output_sel (osel_n),
    .uio        (uio_n)
  );

  // sequencer state, counters and captured operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      load_k   <= 3'd0;
      elem     <= 2'd0;
      sub      <= 2'd0;
      a_cap    <= {VEC_W{1'b0}};
      b_cap    <= {VEC_W{1'b0}};
      c_smp    <= {VEC_W{1'b0}};
`ifdef TPU_SEQ_TIMEOUT_EN
      wait_cnt <= 16'd0;
`endif
    end else begin
      state    <= state_n;
      load_k   <= load_k_n;
      elem     <= elem_n;
      sub      <= sub_n;
`ifdef TPU_SEQ_TIMEOUT_EN
      wait_cnt <= wait_cnt_n;
`endif
      if (capture) begin
        a_cap <= a_flat;
        b_cap <= b_flat;
      end
      if (sample) begin
        c_smp[elem*DATA_W +: DATA_W] <= tpu_uo_out;
      end
    end
  end

  // registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= 1'b0;
      result_valid <= 1'b0;
      c_flat       <= {VEC_W{1'b0}};
      tpu_ui_in    <= {DATA_W{1'b0}};
      tpu_uio_in   <= 8'd0;
`ifdef TPU_SEQ_TIMEOUT_EN
      timeout_err  <= 1'b0;
`endif
    end else begin
      busy         <= (state_n == LOAD) || (state_n == WAIT_DONE) || (state_n == READ);
      result_valid <= (state_n == DONE);
      tpu_ui_in    <= ui_n;
      tpu_uio_in   <= uio_n;
`ifdef TPU_SEQ_TIMEOUT_EN
      timeout_err  <= timeout_hit;
`endif
      // last element bypasses c_smp so c_flat is complete in the DONE cycle
      if (finish_read) begin
        c_flat <= {tpu_uo_out, c_smp[VEC_W-DATA_W-1:0]};
      end
    end
  end

endmodule

// File: tb/tb_tpu_host_seq.sv
// Directed bench for tpu_host_seq with a small behavioural TPU model.
// Define TPU_SEQ_TIMEOUT_EN to also exercise the WAIT_DONE timeout.
module tb_tpu_host_seq;

`ifdef TPU_SEQ_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif

  localparam logic [31:0] A1 = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [31:0] B1 = {8'd8, 8'd7, 8'd6, 8'd5};
  localparam logic [31:0] C1 = {8'd50, 8'd43, 8'd22, 8'd19};
  localparam logic [31:0] A2 = {8'd1, 8'd1, 8'd1, 8'd1};
  localparam logic [31:0] C2 = {8'd14, 8'd12, 8'd14, 8'd12};
  localparam logic [31:0] A3 = {8'd1, 8'd0, 8'd0, 8'd1};
  localparam logic [31:0] B3 = {8'd6, 8'd7, 8'd8, 8'd9};

  logic        clk, rst, start;
  logic [31:0] a_flat, b_flat, c_flat;
  logic        busy, result_valid, tpu_done;
  logic [7:0]  tpu_ui_in, tpu_uio_in, tpu_uo_out;
`ifdef TPU_SEQ_TIMEOUT_EN
  logic        timeout_err;
`endif

  int total = 0;
  int bad   = 0;

  tpu_host_seq #(.DATA_W(8), .READ_LAT(1), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .a_flat       (a_flat),
    .b_flat       (b_flat),
    .busy         (busy),
    .c_flat       (c_flat),
    .result_valid (result_valid),
    .tpu_ui_in    (tpu_ui_in),
    .tpu_uio_in   (tpu_uio_in),
    .tpu_uo_out   (tpu_uo_out),
    .tpu_done     (tpu_done)
`ifdef TPU_SEQ_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TPU model: loads operands, raises done (delayed / held / never), 1-cycle read latency
  logic [7:0] ma [4];
  logic [7:0] mb [4];
  logic [7:0] uo_q;
  logic [1:0] dly;
  logic       armed;
  int         dmode;

  function automatic logic [7:0] cval(input logic [1:0] i);
    int r, c;
    r = i / 2;
    c = i % 2;
    return 8'(ma[2*r] * mb[c] + ma[2*r+1] * mb[2+c]);
  endfunction

  always @(posedge clk) begin
    if (tpu_uio_in[0]) begin
      if (tpu_uio_in[1]) mb[tpu_uio_in[3:2]] <= tpu_ui_in;
      else               ma[tpu_uio_in[3:2]] <= tpu_ui_in;
      if (tpu_uio_in[1] && tpu_uio_in[3:2] == 2'd3) begin
        armed <= 1'b1;
        dly   <= 2'd3;
      end else begin
        armed <= 1'b0;
      end
    end else if (armed && dly != 2'd0) begin
      dly <= dly - 2'd1;
    end
    if (tpu_uio_in[4]) uo_q <= cval(tpu_uio_in[6:5]);
  end

  assign tpu_uo_out = uo_q;
  assign tpu_done   = (dmode == 1) ? 1'b1 : (dmode == 2) ? 1'b0 : (armed && dly == 2'd0);

  logic [7:0]  rec_uio [64];
  logic [7:0]  rec_ui  [64];
  logic        rec_busy[64];
  logic        rec_rv  [64];
  logic        rec_to  [64];
  logic [31:0] rec_c   [64];

  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    a_flat = a;
    b_flat = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // index i holds cycle i+1 after the edge that accepted start
  task automatic record(input int n, input int restart_idx, input logic [31:0] ra, input logic [31:0] rb);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rec_uio[i]  = tpu_uio_in;
      rec_ui[i]   = tpu_ui_in;
      rec_busy[i] = busy;
      rec_rv[i]   = result_valid;
      rec_c[i]    = c_flat;
`ifdef TPU_SEQ_TIMEOUT_EN
      rec_to[i]   = timeout_err;
`else
      rec_to[i]   = 1'b0;
`endif
      if (i == restart_idx) begin
        start  = 1'b1;
        a_flat = ra;
        b_flat = rb;
      end else begin
        start  = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a_flat = 32'd0; b_flat = 32'd0; dmode = 0;
    armed = 1'b0; dly = 2'd0; uo_q = 8'd0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_rv: got %b want 0", result_valid); end
    total++; if (c_flat !== 32'd0) begin bad++; $display("FAIL reset_c: got %h want 0", c_flat); end
    total++; if (tpu_ui_in !== 8'd0) begin bad++; $display("FAIL reset_ui: got %h want 0", tpu_ui_in); end
    total++; if (tpu_uio_in !== 8'd0) begin bad++; $display("FAIL reset_uio: got %h want 0", tpu_uio_in); end
`ifdef TPU_SEQ_TIMEOUT_EN
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_to: got %b want 0", timeout_err); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [2:0] kk;
    logic [7:0] exp_uio;
    int pulses, vidx;
    dmode = 0;
    do_start(A1, B1);
    record(30, -1, 32'd0, 32'd0);
    for (int k = 0; k < 8; k++) begin
      kk = 3'(k);
      exp_uio = {3'b000, 1'b0, kk[1:0], kk[2], 1'b1};
      total++; if (rec_uio[k] !== exp_uio) begin bad++; $display("FAIL basic_load_uio[%0d]: got %h want %h", k, rec_uio[k], exp_uio); end
      total++; if (rec_ui[k] !== 8'(k + 1)) begin bad++; $display("FAIL basic_load_ui[%0d]: got %0d want %0d", k, rec_ui[k], k + 1); end
    end
    total++; if (rec_uio[8] !== 8'd0) begin bad++; $display("FAIL basic_wait_uio: got %h want 0", rec_uio[8]); end
    pulses = 0; vidx = -1;
    for (int i = 0; i < 30; i++) if (rec_rv[i] === 1'b1) begin pulses++; vidx = i; end
    total++; if (pulses !== 1) begin bad++; $display("FAIL basic_pulses: got %0d want 1", pulses); end
    total++; if (vidx !== 20) begin bad++; $display("FAIL basic_latency: got idx %0d want 20", vidx); end
    if (vidx > 0) begin
      total++; if (rec_c[vidx] !== C1) begin bad++; $display("FAIL basic_c: got %h want %h", rec_c[vidx], C1); end
      total++; if (rec_busy[vidx] !== 1'b0) begin bad++; $display("FAIL basic_busy_fall: got %b want 0", rec_busy[vidx]); end
      total++; if (rec_busy[vidx-1] !== 1'b1) begin bad++; $display("FAIL basic_busy_before: got %b want 1", rec_busy[vidx-1]); end
    end
  endtask

  // analyses the uio trace left by test_basic
  task automatic test_protocol;
    int overlap, b7, n_oe, seq_err;
    overlap = 0; b7 = 0; n_oe = 0; seq_err = 0;
    for (int i = 0; i < 30; i++) begin
      if (rec_uio[i][0] && rec_uio[i][4]) overlap++;
      if (rec_uio[i][7]) b7++;
      if (rec_uio[i][4]) begin
        if (rec_uio[i][6:5] !== 2'(n_oe / 2)) seq_err++;
        n_oe++;
      end
    end
    total++; if (overlap !== 0) begin bad++; $display("FAIL proto_overlap: got %0d want 0", overlap); end
    total++; if (b7 !== 0) begin bad++; $display("FAIL proto_bit7: got %0d want 0", b7); end
    total++; if (n_oe !== 8) begin bad++; $display("FAIL proto_oe_cycles: got %0d want 8", n_oe); end
    total++; if (seq_err !== 0) begin bad++; $display("FAIL proto_sel_seq: got %0d errors want 0", seq_err); end
  endtask

  task automatic test_start_while_busy;
    logic [31:0] av, bv;
    logic [7:0]  exp_ui;
    int pulses;
    av = A3; bv = B3;
    dmode = 0;
    do_start(A3, B3);
    record(30, 3, 32'h03030303, 32'h03030303);
    for (int k = 0; k < 8; k++) begin
      exp_ui = (k < 4) ? av[k*8 +: 8] : bv[(k-4)*8 +: 8];
      total++; if (rec_ui[k] !== exp_ui) begin bad++; $display("FAIL swb_ui[%0d]: got %0d want %0d", k, rec_ui[k], exp_ui); end
    end
    pulses = 0;
    for (int i = 0; i < 30; i++) if (rec_rv[i] === 1'b1) pulses++;
    total++; if (pulses !== 1) begin bad++; $display("FAIL swb_pulses: got %0d want 1", pulses); end
    total++; if (rec_c[20] !== B3) begin bad++; $display("FAIL swb_c: got %h want %h", rec_c[20], B3); end
    total++; if (rec_busy[25] !== 1'b0) begin bad++; $display("FAIL swb_no_requeue: busy %b want 0", rec_busy[25]); end
  endtask

  task automatic test_reset_mid_read;
    int pulses;
    dmode = 1;
    do_start(A1, B1);
    repeat (12) @(negedge clk);
    total++; if (tpu_uio_in !== 8'h30) begin bad++; $display("FAIL rst_slot2_uio: got %h want 30", tpu_uio_in); end
    #1 rst = 1'b1;
    #1;
    total++; if ({busy, result_valid} !== 2'b00) begin bad++; $display("FAIL rst_mid_flags: got %b want 00", {busy, result_valid}); end
    total++; if (c_flat !== 32'd0) begin bad++; $display("FAIL rst_mid_c: got %h want 0", c_flat); end
    total++; if ({tpu_ui_in, tpu_uio_in} !== 16'd0) begin bad++; $display("FAIL rst_mid_pins: got %h want 0", {tpu_ui_in, tpu_uio_in}); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (result_valid === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rst_mid_no_rv: got %0d want 0", pulses); end
    do_start(A3, B3);
    record(25, -1, 32'd0, 32'd0);
    total++; if (rec_rv[17] !== 1'b1) begin bad++; $display("FAIL rst_rerun_rv: got %b want 1", rec_rv[17]); end
    total++; if (rec_c[17] !== B3) begin bad++; $display("FAIL rst_rerun_c: got %h want %h", rec_c[17], B3); end
  endtask

  task automatic test_back_to_back;
    int pulses, held_err;
    dmode = 1;
    do_start(A1, B1);
    record(40, 18, A2, B1);
    pulses = 0; held_err = 0;
    for (int i = 0; i < 40; i++) if (rec_rv[i] === 1'b1) pulses++;
    for (int i = 18; i < 36; i++) if (rec_c[i] !== C1) held_err++;
    total++; if (rec_rv[17] !== 1'b1) begin bad++; $display("FAIL b2b_rv1: got %b want 1", rec_rv[17]); end
    total++; if (rec_c[17] !== C1) begin bad++; $display("FAIL b2b_c1: got %h want %h", rec_c[17], C1); end
    total++; if (rec_rv[36] !== 1'b1) begin bad++; $display("FAIL b2b_rv2: got %b want 1", rec_rv[36]); end
    total++; if (rec_c[36] !== C2) begin bad++; $display("FAIL b2b_c2: got %h want %h", rec_c[36], C2); end
    total++; if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    total++; if (held_err !== 0) begin bad++; $display("FAIL b2b_c_hold: got %0d changes want 0", held_err); end
  endtask

`ifdef TPU_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    logic [31:0] c_prev;
    int pulses, to_pulses;
    dmode = 2;
    c_prev = c_flat;
    do_start(A3, B3);
    record(30, -1, 32'd0, 32'd0);
    pulses = 0; to_pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (rec_rv[i] === 1'b1) pulses++;
      if (rec_to[i] === 1'b1) to_pulses++;
    end
    total++; if (rec_rv[18] !== 1'b1) begin bad++; $display("FAIL to_rv: got %b want 1", rec_rv[18]); end
    total++; if (rec_to[18] !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", rec_to[18]); end
    total++; if (rec_c[18] !== c_prev) begin bad++; $display("FAIL to_c: got %h want %h", rec_c[18], c_prev); end
    total++; if (pulses !== 1 || to_pulses !== 1) begin bad++; $display("FAIL to_pulses: got %0d/%0d want 1/1", pulses, to_pulses); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_protocol();
    test_start_while_busy();
    test_reset_mid_read();
    test_back_to_back();
`ifdef TPU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
